// File: rtl/latency_mem_bank_pkg.sv
// Shared types and helpers for the latency memory bank: cell state encoding,
// default widths and a lowest-set-bit priority picker.
package latmem_pkg;

  // Encoding keeps the historical start/trig bit pair of the single-cell design.
  typedef enum logic [1:0] {
    CELL_IDLE      = 2'b00,
    CELL_TOREAD    = 2'b01,
    CELL_COUNTING  = 2'b10,
    CELL_TRIGGERED = 2'b11
  } cell_state_e;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LAT_W  = 9;
  localparam int DEF_TAG_W  = 5;
  localparam int DEF_OVF_W  = 16;
  localparam int MAX_DEPTH  = 32;

  // One-hot of the lowest set bit; all zeros when nothing is set.
  function automatic logic [MAX_DEPTH-1:0] lowest_set(input logic [MAX_DEPTH-1:0] v);
    return v & (-v);
  endfunction

endpackage

// File: rtl/latency_mem_bank_if.sv
// Writer / trigger / readout signal bundle of the latency memory bank.
// slave = the bank, master = the surrounding core-region logic.
interface latency_mem_bank_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int LAT_W  = 9,
  parameter int TAG_W  = 5,
  parameter int OVF_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              WriteLe;
  logic [LAT_W-1:0]  LatCntIn;
  logic [DATA_W-1:0] WriterData;
  logic [LAT_W-1:0]  LatCntReq;
  logic              L1;
  logic [TAG_W-1:0]  L1In;
  logic              ReadReq;
  logic [TAG_W-1:0]  L1Req;
  logic              DataReady;

  logic              DataValid;
  logic [DATA_W-1:0] Data;
  logic              WrDrop;
  logic              Full;
  logic              Empty;
  logic [CNT_W-1:0]  NumFree;
  logic [OVF_W-1:0]  OvfCnt;

  modport master (
    output WriteLe, LatCntIn, WriterData, LatCntReq, L1, L1In, ReadReq, L1Req, DataReady,
    input  DataValid, Data, WrDrop, Full, Empty, NumFree, OvfCnt
  );

  modport slave (
    input  WriteLe, LatCntIn, WriterData, LatCntReq, L1, L1In, ReadReq, L1Req, DataReady,
    output DataValid, Data, WrDrop, Full, Empty, NumFree, OvfCnt
  );

endinterface

// File: rtl/latency_mem_bank_cell.sv
// One latency memory cell: state, timestamp, trigger tag and payload.
// With LATMEM_BANK_CG_EN defined the cell flops run on a gated clock from CG_MOD.
`ifdef LATMEM_BANK_CG_EN
module CG_MOD (
  input  logic Clk,
  input  logic En,
  output logic ClkOut
);
  logic r_en_lat;

  always_latch begin
    if (!Clk) r_en_lat <= En;
  end

  assign ClkOut = Clk & r_en_lat;
endmodule
`endif

module latmem_cell
  import latmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT_W  = DEF_LAT_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc,
  input  logic [LAT_W-1:0]  i_lat_cnt_in,
  input  logic [DATA_W-1:0] i_writer_data,
  input  logic [LAT_W-1:0]  i_lat_cnt_req,
  input  logic              i_l1,
  input  logic [TAG_W-1:0]  i_l1_in,
  input  logic              i_read_req,
  input  logic [TAG_W-1:0]  i_l1_req,
  input  logic              i_pop,
  output cell_state_e       o_state,
  output logic [DATA_W-1:0] o_data
);

  cell_state_e       r_state;
  logic [LAT_W-1:0]  r_stamp;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;

  logic w_expire;
  logic w_rd_match;
  logic w_en;
  logic w_clk;

  assign w_expire   = (r_state == CELL_COUNTING) && (r_stamp == i_lat_cnt_req);
  assign w_rd_match = i_read_req && (r_state == CELL_TRIGGERED) && (r_tag == i_l1_req);
  assign w_en       = i_alloc | w_expire | w_rd_match | i_pop;

`ifdef LATMEM_BANK_CG_EN
  CG_MOD u_cg (
    .Clk    (clk),
    .En     (w_en),
    .ClkOut (w_clk)
  );
`else
  assign w_clk = clk;
`endif

  // The top only allocates IDLE cells and pops TOREAD cells, so at most one
  // branch below can be live for a given cell state.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too; a reset must leave no stale
      // hit data that could be streamed out later.
      r_state <= CELL_IDLE;
      r_stamp <= '0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (w_en) begin
      // NOTE: non-blocking assignments keep every cell register sampling the
      // pre-edge values, independent of statement order.
      if (i_alloc) begin
        r_state <= CELL_COUNTING;
        r_stamp <= i_lat_cnt_in;
        r_data  <= i_writer_data;
      end else if (w_expire) begin
        if (i_l1) begin
          r_state <= CELL_TRIGGERED;
          r_tag   <= i_l1_in;
        end else begin
          r_state <= CELL_IDLE;
        end
      end else if (w_rd_match) begin
        r_state <= CELL_TOREAD;
      end else if (i_pop) begin
        r_state <= CELL_IDLE;
      end
    end
  end

  assign o_state = r_state;
  assign o_data  = r_data;

endmodule

// File: rtl/latency_mem_bank.sv
// Bank of DEPTH latency cells with free-cell allocation, overflow accounting and
// valid/ready readout. Optional per-cell clock gating: LATMEM_BANK_CG_EN.
module latency_mem_bank
  import latmem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT_W  = DEF_LAT_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int OVF_W  = DEF_OVF_W
) (
  input logic               Clk,
  input logic               ResetB,
  latency_mem_bank_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  cell_state_e       w_state     [DEPTH];
  logic [DATA_W-1:0] w_cell_data [DEPTH];

  logic [DEPTH-1:0]  w_idle;
  logic [DEPTH-1:0]  w_toread;
  logic [DEPTH-1:0]  w_first_idle;
  logic [DEPTH-1:0]  w_first_toread;
  logic [DEPTH-1:0]  w_alloc_oh;
  logic [DEPTH-1:0]  w_pop_oh;
  logic [DATA_W-1:0] w_data;
  logic [CNT_W-1:0]  w_num_free;
  logic              w_drop;

  logic              r_wr_drop;
  logic [OVF_W-1:0]  r_ovf_cnt;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    latmem_cell #(
      .DATA_W (DATA_W),
      .LAT_W  (LAT_W),
      .TAG_W  (TAG_W)
    ) u_cell (
      .clk           (Clk),
      .rst_n         (ResetB),
      .i_alloc       (w_alloc_oh[gi]),
      .i_lat_cnt_in  (bus.LatCntIn),
      .i_writer_data (bus.WriterData),
      .i_lat_cnt_req (bus.LatCntReq),
      .i_l1          (bus.L1),
      .i_l1_in       (bus.L1In),
      .i_read_req    (bus.ReadReq),
      .i_l1_req      (bus.L1Req),
      .i_pop         (w_pop_oh[gi]),
      .o_state       (w_state[gi]),
      .o_data        (w_cell_data[gi])
    );

    assign w_idle[gi]   = (w_state[gi] == CELL_IDLE);
    assign w_toread[gi] = (w_state[gi] == CELL_TOREAD);
  end

  // Allocation and presentation both favour the lowest cell index.
  assign w_first_idle   = DEPTH'(lowest_set(MAX_DEPTH'(w_idle)));
  assign w_first_toread = DEPTH'(lowest_set(MAX_DEPTH'(w_toread)));
  assign w_alloc_oh     = bus.WriteLe   ? w_first_idle   : '0;
  assign w_pop_oh       = bus.DataReady ? w_first_toread : '0;
  assign w_drop         = bus.WriteLe && (w_idle == '0);

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value held,
    // which would otherwise infer a latch.
    w_data     = '0;
    w_num_free = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_first_toread[i]) w_data = w_data | w_cell_data[i];
      w_num_free = w_num_free + CNT_W'(w_idle[i]);
    end
  end

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      r_wr_drop <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      r_wr_drop <= w_drop;
      if (w_drop && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
    end
  end

  assign bus.DataValid = |w_toread;
  assign bus.Data      = w_data;
  assign bus.WrDrop    = r_wr_drop;
  assign bus.Full      = (w_idle == '0);
  assign bus.Empty     = &w_idle;
  assign bus.NumFree   = w_num_free;
  assign bus.OvfCnt    = r_ovf_cnt;

endmodule
